// File: rtl/display_scan_scheduler_if.sv
// Value request, conversion status and display pins between the switch-side top level and the scan scheduler.
interface display_scan_scheduler_if;
  logic [15:0] value_in;
  logic        value_valid;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (
    output value_in, value_valid,
    input  busy, done, bcd_out, overflow, seg, an
  );

  modport slave (
    input  value_in, value_valid,
    output busy, done, bcd_out, overflow, seg, an
  );
endinterface

// File: rtl/display_scan_scheduler.sv
// Binary->BCD conversion (shift-add-3) feeding a 4-digit multiplexed seven-segment scan.
// Latency: done pulses in the cycle after edge E+17 for a request sampled at edge E.
// Backpressure: none; requests seen while busy is high are dropped.
module display_scan_scheduler #(
  parameter int REFRESH_DIV   = 100_000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic clk,
  input  logic reset,
  display_scan_scheduler_if.slave io
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [19:0]   scratch;
  logic [15:0]   shreg;
  logic [3:0]    bit_cnt;
  logic          busy_r;
  logic          done_r;
  logic [15:0]   bcd_r;
  logic          ovf_r;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic [6:0]    seg_next;
  logic [19:0]   scratch_adj;
  logic [35:0]   shifted;
  logic [3:0]    digit;
  logic          higher_zero;

  function automatic logic [19:0] add3(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign scratch_adj = add3(scratch);
  assign shifted     = {scratch_adj, shreg} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      scratch <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (io.value_valid) begin
            shreg   <= io.value_in;
            scratch <= '0;
            bit_cnt <= '0;
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[35:16];
          shreg   <= shifted[15:0];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= DONE;
        end
        DONE: begin
          bcd_r  <= scratch[15:0];
          ovf_r  <= |scratch[19:16];
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    digit       = bcd_r[{idx, 2'b00} +: 4];
    higher_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(idx) && bcd_r[4*i +: 4] != 4'd0) higher_zero = 1'b0;
    end
    if (ovf_r)
      seg_next = 7'b0111111;
    else if (BLANK_LEADING && idx != 2'd0 && higher_zero)
      seg_next = 7'b1111111;
    else
      seg_next = encode(digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= '0;
      an_r        <= 4'b1111;
      seg_r       <= 7'b1111111;
    end else begin
      if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an_r  <= ~(4'b0001 << idx);
      seg_r <= seg_next;
    end
  end

  assign io.busy     = busy_r;
  assign io.done     = done_r;
  assign io.bcd_out  = bcd_r;
  assign io.overflow = ovf_r;
  assign io.an       = an_r;
  assign io.seg      = seg_r;
endmodule

// File: tb/tb_display_scan_scheduler.sv
// Random and directed stimulus for display_scan_scheduler, checked every cycle against a decimal-arithmetic model.
module tb_display_scan_scheduler;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  display_scan_scheduler_if ifb();
  display_scan_scheduler_if ifn();

  display_scan_scheduler #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .reset(reset), .io(ifb.slave));
  display_scan_scheduler #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) dut_n (
    .clk(clk), .reset(reset), .io(ifn.slave));

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int r;
    r = v % 10000;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] bcd, input logic ovf,
                                         input int slot, input bit blank);
    int d [4];
    bit lead;
    for (int i = 0; i < 4; i++) d[i] = int'(bcd[4*i +: 4]);
    if (ovf) return 7'b0111111;
    lead = 1'b1;
    for (int j = slot; j < 4; j++) if (d[j] != 0) lead = 1'b0;
    if (blank && slot > 0 && lead) return 7'b1111111;
    if (d[slot] > 9) return 7'b1111111;
    return seg_tab[d[slot]];
  endfunction

  // Model: a request starts a 17-edge countdown; the scan slot is simply the edge count divided by DIV.
  logic        model_ok = 1'b0;
  int          m_cnt, m_val, m_k, slot;
  logic [15:0] m_bcd;
  logic        m_ovf, m_done;
  logic [3:0]  m_an;
  logic [6:0]  m_seg_b, m_seg_n;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cnt = 0; m_bcd = '0; m_ovf = 1'b0; m_done = 1'b0; m_k = 0;
        m_an = 4'b1111; m_seg_b = 7'b1111111; m_seg_n = 7'b1111111;
        model_ok = 1'b1;
      end else begin
        slot = (m_k / DIV) % 4;
        m_an = 4'b1111;
        m_an[slot] = 1'b0;
        m_seg_b = exp_seg(m_bcd, m_ovf, slot, 1'b1);
        m_seg_n = exp_seg(m_bcd, m_ovf, slot, 1'b0);
        m_k++;
        m_done = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_bcd  = to_bcd(m_val);
            m_ovf  = (m_val > 9999);
            m_done = 1'b1;
          end
        end else if (ifb.value_valid) begin
          m_cnt = 17;
          m_val = int'(ifb.value_in);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("busy",     ifb.busy,     m_cnt > 0);
        check("done",     ifb.done,     m_done);
        check("bcd_out",  ifb.bcd_out,  m_bcd);
        check("overflow", ifb.overflow, m_ovf);
        check("an",       ifb.an,       m_an);
        check("seg",      ifb.seg,      m_seg_b);
        check("seg_noblank", ifn.seg,   m_seg_n);
        check("done_noblank", ifn.done, m_done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] v, input logic vld);
    ifb.value_in = v; ifb.value_valid = vld;
    ifn.value_in = v; ifn.value_valid = vld;
  endtask

  task automatic request(input logic [15:0] v);
    set_in(v, 1'b1);
    tick();
    set_in(v, 1'b0);
  endtask

  task automatic wait_done(output int busy_cyc, output bit seen);
    busy_cyc = 0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (ifb.done) seen = 1'b1;
      else begin
        if (ifb.busy) busy_cyc++;
        tick();
      end
    end
  endtask

  task automatic count_done(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ifb.done) dones++;
    end
  endtask

  // Expected seg per slot packed as {slot3, slot2, slot1, slot0}.
  task automatic scan_check(input string nm, input logic [27:0] eb, input logic [27:0] en);
    int s;
    for (int c = 0; c < 16; c++) begin
      case (ifb.an)
        4'b1110: s = 0;
        4'b1101: s = 1;
        4'b1011: s = 2;
        4'b0111: s = 3;
        default: s = -1;
      endcase
      if (s < 0) check({nm, "_an_onehot"}, ifb.an, 4'b1110);
      else begin
        check({nm, "_seg"}, ifb.seg, eb[7*s +: 7]);
        check({nm, "_seg_noblank"}, ifn.seg, en[7*s +: 7]);
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010, S6 = 7'b0000010, S8 = 7'b0000000, S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111, DA = 7'b0111111;

  initial begin
    int  bc, nd;
    bit  seen;
    logic [15:0] v;

    set_in(16'd0, 1'b0);
    reset = 1'b1;
    repeat (3) tick();
    check("rst_busy", ifb.busy, 1'b0);
    check("rst_done", ifb.done, 1'b0);
    check("rst_bcd",  ifb.bcd_out, 16'h0000);
    check("rst_ovf",  ifb.overflow, 1'b0);
    check("rst_an",   ifb.an, 4'b1111);
    check("rst_seg",  ifb.seg, 7'b1111111);
    reset = 1'b0;
    tick();
    check("first_an", ifb.an, 4'b1110);

    request(16'd456);
    wait_done(bc, seen);
    check("t1_done_seen", seen, 1'b1);
    check("t1_busy_len", bc, 17);
    check("t1_bcd", ifb.bcd_out, 16'h0456);
    check("t1_ovf", ifb.overflow, 1'b0);
    count_done(6, nd);
    check("t1_single_done", nd, 0);
    scan_check("t1", {BL, S4, S5, S6}, {S0, S4, S5, S6});

    request(16'd0);
    wait_done(bc, seen);
    check("t2_done_seen", seen, 1'b1);
    check("t2_bcd", ifb.bcd_out, 16'h0000);
    count_done(4, nd);
    scan_check("t2", {BL, BL, BL, S0}, {S0, S0, S0, S0});

    request(16'd9998);
    wait_done(bc, seen);
    check("t3a_bcd", ifb.bcd_out, 16'h9998);
    check("t3a_ovf", ifb.overflow, 1'b0);
    count_done(4, nd);
    scan_check("t3a", {S9, S9, S9, S8}, {S9, S9, S9, S8});
    request(16'd16012);
    wait_done(bc, seen);
    check("t3b_bcd", ifb.bcd_out, 16'h6012);
    check("t3b_ovf", ifb.overflow, 1'b1);
    count_done(4, nd);
    scan_check("t3b", {DA, DA, DA, DA}, {DA, DA, DA, DA});

    request(16'd652);
    repeat (4) tick();
    request(16'd1024);
    count_done(30, nd);
    check("t4_one_done", nd, 1);
    check("t4_bcd", ifb.bcd_out, 16'h0652);
    check("t4_idle", ifb.busy, 1'b0);

    request(16'd777);
    repeat (7) tick();
    check("t5_busy_before", ifb.busy, 1'b1);
    reset = 1'b1;
    tick();
    check("t5_busy", ifb.busy, 1'b0);
    check("t5_done", ifb.done, 1'b0);
    check("t5_bcd", ifb.bcd_out, 16'h0000);
    check("t5_an", ifb.an, 4'b1111);
    reset = 1'b0;
    count_done(30, nd);
    check("t5_no_done", nd, 0);

    request(16'd65535);
    wait_done(bc, seen);
    check("t6a_bcd", ifb.bcd_out, 16'h5535);
    check("t6a_ovf", ifb.overflow, 1'b1);
    request(16'd1024);
    wait_done(bc, seen);
    check("t6b_done_seen", seen, 1'b1);
    check("t6b_bcd", ifb.bcd_out, 16'h1024);
    check("t6b_ovf", ifb.overflow, 1'b0);
    count_done(4, nd);
    scan_check("t6b", {S1, S0, S2, S4}, {S1, S0, S2, S4});

    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 4))
        0:       v = 16'd0;
        1:       v = 16'd9999;
        2:       v = 16'd10000;
        3:       v = 16'($urandom_range(0, 65535));
        default: v = 16'($urandom_range(0, 9999));
      endcase
      set_in(v, $urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    set_in(16'd0, 1'b0);
    repeat (25) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
